// File: rtl/fp16_add_arbiter.sv
// Round-robin front end that shares one external combinational FP16 adder between NUM_REQ
// requesters and returns each sum on a single tagged valid/ready response channel.
module fp16_add_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [16*NUM_REQ-1:0]  req_a_i,
    input  logic [16*NUM_REQ-1:0]  req_b_i,
    output logic [15:0]            add_f1_o,
    output logic [15:0]            add_f2_o,
    input  logic [15:0]            add_f3_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [ID_W-1:0]        rsp_id_o,
    output logic [15:0]            rsp_data_o,
    output logic                   busy_o,
    output logic [CNT_W-1:0]       op_count_o
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e            state_q;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   gnt_id_q;
    logic [15:0]       op_a_q;
    logic [15:0]       op_b_q;
    logic              rsp_valid_q;
    logic [15:0]       rsp_data_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic [CNT_W-1:0]  op_count_q;
    logic [CNT_W-1:0]  op_count_d;

    logic              grant_vld;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W:0]     scan;
    logic [ID_W-1:0]   rr_next;
    logic              rsp_hs;

    // First valid requester starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        scan      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (scan >= (ID_W+1)'(NUM_REQ)) begin
                scan = scan - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_vld && req_valid_i[scan[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_id  = scan[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (rst_ni && (state_q == StIdle) && grant_vld) begin
            req_ready_o[grant_id] = 1'b1;
        end
    end

    assign rsp_hs     = (state_q == StResp) && rsp_ready_i;
    assign rr_next    = (gnt_id_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
    assign op_count_d = op_count_q + CNT_W'(rsp_hs);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            gnt_id_q    <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            op_count_q  <= '0;
        end else begin
            op_count_q <= op_count_d;
            case (state_q)
                StIdle: begin
                    if (grant_vld) begin
                        op_a_q   <= req_a_i[grant_id*16 +: 16];
                        op_b_q   <= req_b_i[grant_id*16 +: 16];
                        gnt_id_q <= grant_id;
                        state_q  <= StExec;
                    end
                end
                StExec: begin
                    rsp_data_q  <= add_f3_i;
                    rsp_id_q    <= gnt_id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= StResp;
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        rr_ptr_q    <= rr_next;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign add_f1_o    = op_a_q;
    assign add_f2_o    = op_b_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_id_o    = rsp_id_q;
    assign busy_o      = (state_q != StIdle);
    assign op_count_o  = op_count_q;

endmodule
